control_secuencia_stepper: RTL and testbench

Step-sequencing controller for one unipolar/bipolar 4-wire stepper motor. Consumes the 8-bit speed magnitude and direction bit produced by the UART stepper-message detector. Generates a ramped step rate through a phase accumulator and drives the coil phase pattern. Reversals always decelerate to zero before the direction is changed. Sits between the message detector and the coil driver pins.

---
 rtl/control_secuencia_stepper.sv | 165 ++++++++++++++++
 tb/tb_control_secuencia_stepper.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_secuencia_stepper.sv
`default_nettype none
// control_secuencia_stepper: ramped phase-accumulator step sequencer driving a 4-wire stepper.
// Build option HALF_STEP_EN selects the 8-pattern half-step sequence instead of full steps.
module control_secuencia_stepper #(
    parameter int TICK_DIV   = 50000,
    parameter int RAMP_TICKS = 4
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [7:0] VELOCIDAD,
    input  logic       DIRECCION,
    input  logic       ENABLE,
    output logic [3:0] BOBINAS,
    output logic       PASO,
    output logic [7:0] VEL_ACTUAL,
    output logic       DIR_ACTUAL,
    output logic [2:0] ESTADO
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_TICKS - 1);
`ifdef HALF_STEP_EN
    localparam int IW = 3;
`else
    localparam int IW = 2;
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCEL   = 3'd1,
        CRUISE  = 3'd2,
        DECEL   = 3'd3,
        REVERSE = 3'd4
    } state_t;

    logic [TW-1:0] tick_q, tick_d;
    logic [RW-1:0] ramp_q, ramp_d;
    logic [7:0]    acc_q, acc_d;
    logic [7:0]    vel_q, vel_d;
    logic          dir_q, dir_d;
    logic          paso_q, paso_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [3:0]    bob_q, bob_d;
    state_t        state_q, state_d;
    state_t        state_cls;
    logic          tick;
    logic [7:0]    target;
    logic [8:0]    sum;

    function automatic logic [3:0] patron(input logic [IW-1:0] i);
`ifdef HALF_STEP_EN
        case (i)
            3'd0:    patron = 4'b1000;
            3'd1:    patron = 4'b1100;
            3'd2:    patron = 4'b0100;
            3'd3:    patron = 4'b0110;
            3'd4:    patron = 4'b0010;
            3'd5:    patron = 4'b0011;
            3'd6:    patron = 4'b0001;
            default: patron = 4'b1001;
        endcase
`else
        case (i)
            2'd0:    patron = 4'b1100;
            2'd1:    patron = 4'b0110;
            2'd2:    patron = 4'b0011;
            default: patron = 4'b1001;
        endcase
`endif
    endfunction

    // A pending reversal forces the ramp down to zero before the direction may change.
    assign tick   = (tick_q == TICK_LAST);
    assign target = (DIRECCION != dir_q) ? 8'd0 : VELOCIDAD;
    assign sum    = {1'b0, acc_q} + {1'b0, vel_q};

    always_comb begin
        tick_d = tick_q;
        ramp_d = ramp_q;
        acc_d  = acc_q;
        vel_d  = vel_q;
        dir_d  = dir_q;
        idx_d  = idx_q;
        paso_d = 1'b0;
        if (!ENABLE) begin
            tick_d = '0;
            ramp_d = '0;
            acc_d  = 8'd0;
            vel_d  = 8'd0;
            dir_d  = DIRECCION;
        end else begin
            tick_d = tick ? '0 : tick_q + 1'b1;
            if (tick) begin
                ramp_d = (ramp_q == RAMP_LAST) ? '0 : ramp_q + 1'b1;
                acc_d  = sum[7:0];
                if (sum[8]) begin
                    paso_d = 1'b1;
                    idx_d  = dir_q ? idx_q + 1'b1 : idx_q - 1'b1;
                end
                if (vel_q == 8'd0) begin
                    dir_d = DIRECCION;
                end
                if (ramp_q == RAMP_LAST) begin
                    if (vel_q < target) begin
                        vel_d = vel_q + 8'd1;
                    end else if (vel_q > target) begin
                        vel_d = vel_q - 8'd1;
                    end
                end
            end
        end
        bob_d = ENABLE ? patron(idx_d) : 4'b0000;
    end

    always_comb begin
        state_cls = IDLE;
        if (!ENABLE) begin
            state_cls = IDLE;
        end else if ((DIRECCION != dir_q) && (vel_q != 8'd0)) begin
            state_cls = REVERSE;
        end else if (vel_q < target) begin
            state_cls = ACCEL;
        end else if (vel_q > target) begin
            state_cls = DECEL;
        end else if (vel_q != 8'd0) begin
            state_cls = CRUISE;
        end
        case (state_q)
            IDLE, ACCEL, CRUISE, DECEL, REVERSE: state_d = state_cls;
            default:                             state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            tick_q  <= '0;
            ramp_q  <= '0;
            acc_q   <= 8'd0;
            vel_q   <= 8'd0;
            dir_q   <= 1'b1;
            idx_q   <= '0;
            paso_q  <= 1'b0;
            bob_q   <= 4'b0000;
            state_q <= IDLE;
        end else begin
            tick_q  <= tick_d;
            ramp_q  <= ramp_d;
            acc_q   <= acc_d;
            vel_q   <= vel_d;
            dir_q   <= dir_d;
            idx_q   <= idx_d;
            paso_q  <= paso_d;
            bob_q   <= bob_d;
            state_q <= state_d;
        end
    end

    assign BOBINAS    = bob_q;
    assign PASO       = paso_q;
    assign VEL_ACTUAL = vel_q;
    assign DIR_ACTUAL = dir_q;
    assign ESTADO     = state_q;
endmodule
`default_nettype wire

// File: tb/tb_control_secuencia_stepper.sv
`default_nettype none
// tb_control_secuencia_stepper: table-driven and scoreboard checks of the stepper sequencer.
module tb_control_secuencia_stepper;
    localparam int TD = 4;
    localparam int RT = 2;
`ifdef HALF_STEP_EN
    localparam int NPAT = 8;
`else
    localparam int NPAT = 4;
`endif
    localparam int ST_IDLE    = 0;
    localparam int ST_ACCEL   = 1;
    localparam int ST_CRUISE  = 2;
    localparam int ST_DECEL   = 3;
    localparam int ST_REVERSE = 4;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [7:0] vel_in = 8'd0;
    logic       dir_in = 1'b1;
    logic       en     = 1'b0;
    logic [3:0] BOBINAS;
    logic       PASO;
    logic [7:0] VEL_ACTUAL;
    logic       DIR_ACTUAL;
    logic [2:0] ESTADO;

    control_secuencia_stepper #(.TICK_DIV(TD), .RAMP_TICKS(RT)) dut (
        .CLOCK_50   (clk),
        .RESET_N    (rst_n),
        .VELOCIDAD  (vel_in),
        .DIRECCION  (dir_in),
        .ENABLE     (en),
        .BOBINAS    (BOBINAS),
        .PASO       (PASO),
        .VEL_ACTUAL (VEL_ACTUAL),
        .DIR_ACTUAL (DIR_ACTUAL),
        .ESTADO     (ESTADO)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       en;
        logic [7:0] vel;
        logic       dir;
        int         exp_vel;
        int         exp_dir;
        int         exp_st;
        int         exp_bob;   // pattern index, -1 = not checked
        int         exp_paso;  // pulses since segment start, -1 = not checked
    } row_t;

    row_t       rows[13];
    logic [3:0] sb_q[$];
    int         n_checks   = 0;
    int         n_fail     = 0;
    int         seg_pulses = 0;
    int         cyc_cnt    = 0;
    int         last_paso  = -1;
    int         min_gap    = 1000000;

    function automatic logic [3:0] pat(input int idx);
        int m;
        logic [3:0] p;
        m = idx % NPAT;
        p = 4'b0000;
`ifdef HALF_STEP_EN
        case (m)
            0: p = 4'b1000;
            1: p = 4'b1100;
            2: p = 4'b0100;
            3: p = 4'b0110;
            4: p = 4'b0010;
            5: p = 4'b0011;
            6: p = 4'b0001;
            default: p = 4'b1001;
        endcase
`else
        case (m)
            0: p = 4'b1100;
            1: p = 4'b0110;
            2: p = 4'b0011;
            default: p = 4'b1001;
        endcase
`endif
        return p;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Each step taken must show the next expected coil pattern.
    always @(negedge clk) begin
        logic [3:0] e;
        if (rst_n && PASO && (sb_q.size() > 0)) begin
            e = sb_q.pop_front();
            chk("step_pattern", int'(BOBINAS), int'(e));
        end
    end

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            cyc_cnt++;
            if (PASO) begin
                seg_pulses++;
                if (last_paso >= 0 && (cyc_cnt - last_paso) < min_gap)
                    min_gap = cyc_cnt - last_paso;
                last_paso = cyc_cnt;
            end
        end
    endtask

    task automatic apply_rows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            en     = rows[i].en;
            vel_in = rows[i].vel;
            dir_in = rows[i].dir;
            run_cycles(rows[i].cyc);
            chk($sformatf("row%0d_vel", i), int'(VEL_ACTUAL), rows[i].exp_vel);
            chk($sformatf("row%0d_dir", i), int'(DIR_ACTUAL), rows[i].exp_dir);
            chk($sformatf("row%0d_estado", i), int'(ESTADO), rows[i].exp_st);
            if (rows[i].exp_bob >= 0)
                chk($sformatf("row%0d_bobinas", i), int'(BOBINAS), int'(pat(rows[i].exp_bob)));
            if (rows[i].exp_paso >= 0)
                chk($sformatf("row%0d_paso_count", i), seg_pulses, rows[i].exp_paso);
        end
    endtask

    task automatic wait_vel(input string name, input int target, input int budget);
        int t;
        t = 0;
        while (int'(VEL_ACTUAL) != target && t < budget) begin
            run_cycles(1);
            t++;
        end
        chk(name, int'(VEL_ACTUAL), target);
    endtask

    task automatic wait_paso(input string name, input int n, input int budget, input int gap);
        int got;
        int t;
        int last;
        got  = 0;
        t    = 0;
        last = -1;
        while (got < n && t < budget) begin
            run_cycles(1);
            t++;
            if (PASO) begin
                if (gap > 0 && last >= 0)
                    chk({name, "_gap"}, t - last, gap);
                last = t;
                got++;
            end
        end
        chk({name, "_count"}, got, n);
        #1;
        chk({name, "_sb_empty"}, sb_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Acceleration from reset to 128, then reversal from cruise at 4.
        rows[0]  = '{1,    1'b1, 8'd128, 1'b1, 0,   1, ST_ACCEL,   0,  0};
        rows[1]  = '{7,    1'b1, 8'd128, 1'b1, 1,   1, ST_ACCEL,   -1, -1};
        rows[2]  = '{1016, 1'b1, 8'd128, 1'b1, 128, 1, ST_ACCEL,   63, 63};
        rows[3]  = '{1,    1'b1, 8'd128, 1'b1, 128, 1, ST_CRUISE,  63, 63};
        rows[4]  = '{1,    1'b1, 8'd4,   1'b0, 4,   1, ST_REVERSE, -1, -1};
        rows[5]  = '{3,    1'b1, 8'd4,   1'b0, 3,   1, ST_REVERSE, -1, -1};
        rows[6]  = '{24,   1'b1, 8'd4,   1'b0, 0,   1, ST_REVERSE, -1, -1};
        rows[7]  = '{1,    1'b1, 8'd4,   1'b0, 0,   1, ST_IDLE,    2,  -1};
        rows[8]  = '{3,    1'b1, 8'd4,   1'b0, 0,   0, ST_IDLE,    -1, -1};
        rows[9]  = '{1,    1'b1, 8'd4,   1'b0, 0,   0, ST_ACCEL,   -1, -1};
        rows[10] = '{3,    1'b1, 8'd4,   1'b0, 1,   0, ST_ACCEL,   -1, -1};
        rows[11] = '{24,   1'b1, 8'd4,   1'b0, 4,   0, ST_ACCEL,   -1, -1};
        rows[12] = '{1,    1'b1, 8'd4,   1'b0, 4,   0, ST_CRUISE,  2,  0};

        // Reset dominates an enabled, reverse-requesting input set.
        rst_n  = 1'b0;
        en     = 1'b1;
        dir_in = 1'b0;
        vel_in = 8'd50;
        run_cycles(3);
        chk("reset_bobinas", int'(BOBINAS), 0);
        chk("reset_paso", int'(PASO), 0);
        chk("reset_vel", int'(VEL_ACTUAL), 0);
        chk("reset_dir", int'(DIR_ACTUAL), 1);
        chk("reset_estado", int'(ESTADO), ST_IDLE);

        rst_n      = 1'b1;
        seg_pulses = 0;
        apply_rows(0, 3);
        for (int i = 1; i <= 9; i++) sb_q.push_back(pat(63 + i));
        wait_paso("cruise128_steps", 9, 90, 8);

        vel_in = 8'd255;
        wait_vel("reach_255", 255, 1100);
        run_cycles(1);
        chk("cruise255_estado", int'(ESTADO), ST_CRUISE);
        seg_pulses = 0;
        last_paso  = -1;
        min_gap    = 1000000;
        run_cycles(TD * 256);
        chk("cruise255_pulses_per_256_ticks", seg_pulses, 255);
        chk("cruise255_min_gap_ge_tick", int'(min_gap >= TD), 1);

        vel_in = 8'd100;
        run_cycles(1);
        chk("decel_estado", int'(ESTADO), ST_DECEL);
        wait_vel("reach_100", 100, 1300);
        run_cycles(1);
        chk("cruise100_estado", int'(ESTADO), ST_CRUISE);

        en = 1'b0;
        run_cycles(1);
        chk("disable_bobinas", int'(BOBINAS), 0);
        chk("disable_vel", int'(VEL_ACTUAL), 0);
        chk("disable_estado", int'(ESTADO), ST_IDLE);
        chk("disable_paso", int'(PASO), 0);
        seg_pulses = 0;
        run_cycles(40);
        chk("disabled_no_paso", seg_pulses, 0);
        chk("disabled_bobinas_hold_off", int'(BOBINAS), 0);
        dir_in = 1'b0;
        run_cycles(1);
        chk("disabled_dir_follows_0", int'(DIR_ACTUAL), 0);
        dir_in = 1'b1;
        run_cycles(1);
        chk("disabled_dir_follows_1", int'(DIR_ACTUAL), 1);

        en     = 1'b1;
        vel_in = 8'd100;
        wait_vel("reach_50", 50, 500);
        chk("accel50_estado", int'(ESTADO), ST_ACCEL);
        rst_n  = 1'b0;
        dir_in = 1'b0;
        run_cycles(1);
        chk("midreset_bobinas", int'(BOBINAS), 0);
        chk("midreset_paso", int'(PASO), 0);
        chk("midreset_vel", int'(VEL_ACTUAL), 0);
        chk("midreset_dir", int'(DIR_ACTUAL), 1);
        chk("midreset_estado", int'(ESTADO), ST_IDLE);

        rst_n  = 1'b1;
        dir_in = 1'b1;
        vel_in = 8'd4;
        sb_q.push_back(pat(1));
        sb_q.push_back(pat(2));
        wait_paso("fwd4_steps", 2, 600, 256);
        seg_pulses = 0;
        apply_rows(4, 12);
        sb_q.push_back(pat(1));
        sb_q.push_back(pat(0));
        wait_paso("rev4_steps", 2, 700, 256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
